// File: rtl/aer_event_sender.sv
// rtl/aer_event_sender.sv - 4-phase AER link driver between the ROC pixel encoder and the SNN core
//
// Takes each index reported by the pixel encoder and sends it to the SNN core
// over a 10-bit AER link with a 4-phase REQ/ACK handshake. The block also
// stalls the encoder while a transfer is in flight, synchronises the
// asynchronous ACK, aborts stuck handshakes, and keeps event/error status.
//
// Ports:
//   CLK              in   system clock, rising edge
//   RST              in   synchronous active-low reset
//   EVT_VALID        in   encoder strobe (single- or multi-cycle)
//   EVT_DATA         in   encoder index, valid one cycle after the strobe starts
//   AERIN_CTRL_BUSY  out  stall to encoder (combinational)
//   AEROUT_ADDR      out  AER address, held from capture until the next capture
//   AEROUT_REQ       out  AER request, registered
//   AEROUT_ACK       in   AER acknowledge, asynchronous
//   EVT_SENT_CNT     out  completed handshakes, saturating
//   ERR_TIMEOUT      out  sticky, a handshake was aborted
//   ERR_OVERRUN      out  sticky, a new strobe arrived while busy
//   CLR_STATUS       in   clears the counter and both error flags

module aer_event_sender #(
    parameter int ADDR_BITS      = 10,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CNT_BITS       = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EVT_VALID,
    input  logic [ADDR_BITS-1:0] EVT_DATA,
    output logic                 AERIN_CTRL_BUSY,
    output logic [ADDR_BITS-1:0] AEROUT_ADDR,
    output logic                 AEROUT_REQ,
    input  logic                 AEROUT_ACK,
    output logic [CNT_BITS-1:0]  EVT_SENT_CNT,
    output logic                 ERR_TIMEOUT,
    output logic                 ERR_OVERRUN,
    input  logic                 CLR_STATUS
);

    localparam int                   TMO_BITS = $clog2(TIMEOUT_CYCLES + 1);
    // The counter starts at 0 on entry, so the last permitted cycle is at TIMEOUT_CYCLES-1.
    localparam logic [TMO_BITS-1:0]  TMO_LAST = TMO_BITS'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_BITS-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LATCH  = 2'd1,
        S_REQ    = 2'd2,
        S_ACK_HI = 2'd3
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic [TMO_BITS-1:0]    tmo_cnt;
    logic                   evt_valid_q;

    logic                   ack_s;
    logic                   evt_rise;
    logic                   tmo_hit;
    logic                   hs_done;
    logic                   hs_abort;
    logic                   overrun;

    always_comb begin
        ack_s    = ack_sync[SYNC_STAGES-1];
        // Only a fresh strobe (low on the previous cycle) is an event; a held
        // level must drop for a cycle before it can start another one.
        evt_rise = EVT_VALID & ~evt_valid_q;
        tmo_hit  = (tmo_cnt == TMO_LAST);
        hs_done  = (state == S_ACK_HI) && !ack_s;
        hs_abort = ((state == S_REQ)    && !ack_s && tmo_hit) ||
                   ((state == S_ACK_HI) &&  ack_s && tmo_hit);
        overrun  = (state != S_IDLE) && evt_rise;
    end

    // Busy must reach the encoder in the same cycle as its strobe.
    assign AERIN_CTRL_BUSY = (state != S_IDLE) || ((state == S_IDLE) && EVT_VALID);

    // ACK synchroniser and strobe edge history.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            ack_sync    <= '0;
            evt_valid_q <= 1'b0;
        end else begin
            ack_sync    <= {ack_sync[SYNC_STAGES-2:0], AEROUT_ACK};
            evt_valid_q <= EVT_VALID;
        end
    end

    // Handshake FSM with registered REQ/ADDR; the timeout counter restarts on
    // every state change.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= S_IDLE;
            tmo_cnt     <= '0;
            AEROUT_REQ  <= 1'b0;
            AEROUT_ADDR <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tmo_cnt    <= '0;
                    AEROUT_REQ <= 1'b0;
                    if (evt_rise) begin
                        state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    // The encoder registers its index one cycle after the strobe.
                    AEROUT_ADDR <= EVT_DATA;
                    AEROUT_REQ  <= 1'b1;
                    tmo_cnt     <= '0;
                    state       <= S_REQ;
                end
                S_REQ: begin
                    if (ack_s) begin
                        AEROUT_REQ <= 1'b0;
                        tmo_cnt    <= '0;
                        state      <= S_ACK_HI;
                    end else if (tmo_hit) begin
                        AEROUT_REQ <= 1'b0;
                        tmo_cnt    <= '0;
                        state      <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_ACK_HI: begin
                    if (!ack_s) begin
                        tmo_cnt <= '0;
                        state   <= S_IDLE;
                    end else if (tmo_hit) begin
                        tmo_cnt <= '0;
                        state   <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    AEROUT_REQ <= 1'b0;
                    tmo_cnt    <= '0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

    // Status: a clear in the same cycle as an update wins.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            EVT_SENT_CNT <= '0;
            ERR_TIMEOUT  <= 1'b0;
            ERR_OVERRUN  <= 1'b0;
        end else if (CLR_STATUS) begin
            EVT_SENT_CNT <= '0;
            ERR_TIMEOUT  <= 1'b0;
            ERR_OVERRUN  <= 1'b0;
        end else begin
            if (hs_done && (EVT_SENT_CNT != CNT_MAX)) begin
                EVT_SENT_CNT <= EVT_SENT_CNT + 1'b1;
            end
            if (hs_abort) begin
                ERR_TIMEOUT <= 1'b1;
            end
            if (overrun) begin
                ERR_OVERRUN <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aer_event_sender.sv
// tb/tb_aer_event_sender.sv - table-driven self-checking bench for aer_event_sender

module tb_aer_event_sender;

    localparam int AB  = 10;
    localparam int TMO = 8;
    localparam int CB  = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          EVT_VALID = 1'b0;
    logic [AB-1:0] EVT_DATA = '0;
    logic          AERIN_CTRL_BUSY;
    logic [AB-1:0] AEROUT_ADDR;
    logic          AEROUT_REQ;
    logic          AEROUT_ACK;
    logic [CB-1:0] EVT_SENT_CNT;
    logic          ERR_TIMEOUT;
    logic          ERR_OVERRUN;
    logic          CLR_STATUS = 1'b0;

    always #5 CLK = ~CLK;

    aer_event_sender #(
        .ADDR_BITS(AB), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO), .CNT_BITS(CB)
    ) dut (
        .CLK(CLK), .RST(RST), .EVT_VALID(EVT_VALID), .EVT_DATA(EVT_DATA),
        .AERIN_CTRL_BUSY(AERIN_CTRL_BUSY), .AEROUT_ADDR(AEROUT_ADDR),
        .AEROUT_REQ(AEROUT_REQ), .AEROUT_ACK(AEROUT_ACK),
        .EVT_SENT_CNT(EVT_SENT_CNT), .ERR_TIMEOUT(ERR_TIMEOUT),
        .ERR_OVERRUN(ERR_OVERRUN), .CLR_STATUS(CLR_STATUS)
    );

    // Core model: ACK echoes REQ three cycles later; ack_en=0 holds ACK low.
    bit         ack_en = 1'b1;
    logic [2:0] ack_dly = '0;
    always @(posedge CLK) ack_dly <= {ack_dly[1:0], AEROUT_REQ};
    assign AEROUT_ACK = ack_en & ack_dly[2];

    // Link log: address seen at every REQ rising edge.
    logic [AB-1:0] link_q[$];
    logic          req_prev = 1'b0;
    always @(negedge CLK) begin
        if (AEROUT_REQ && !req_prev) link_q.push_back(AEROUT_ADDR);
        req_prev = AEROUT_REQ;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_pulse;
        CLR_STATUS = 1'b1;
        tick;
        CLR_STATUS = 1'b0;
    endtask

    // One event from IDLE; garbage on EVT_DATA outside the capture cycle.
    task automatic send_event(input logic [AB-1:0] d, output int req_cycles,
                              output logic [AB-1:0] addr_seen);
        req_cycles = 0;
        check("busy_before", AERIN_CTRL_BUSY, 0);
        EVT_VALID = 1'b1;
        EVT_DATA  = ~d;
        #1;
        check("busy_strobe", AERIN_CTRL_BUSY, 1);
        tick;
        EVT_VALID = 1'b0;
        EVT_DATA  = d;
        check("req_lat1", AEROUT_REQ, 0);
        check("busy_latch", AERIN_CTRL_BUSY, 1);
        tick;
        EVT_DATA = ~d;
        check("req_lat2", AEROUT_REQ, 1);
        addr_seen = AEROUT_ADDR;
        for (int k = 0; k < 60; k++) begin
            if (AEROUT_REQ) req_cycles++;
            if (!AERIN_CTRL_BUSY) break;
            tick;
        end
        check("busy_drop", AERIN_CTRL_BUSY, 0);
        check("addr_hold", AEROUT_ADDR, d);
    endtask

    typedef struct {
        logic [AB-1:0] data;
        bit            ack_on;
        bit            clr_before;
        int            gap;
        int            exp_req_cycles;
        logic [CB-1:0] exp_cnt;
        bit            exp_tmo;
    } vec_t;

    vec_t          vt[11];
    logic [AB-1:0] exp_link[3];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            rc;
        logic [AB-1:0] a;
        bit            seen;

        // data, ack_on, clr_before, gap, req_cycles, cnt, tmo
        vt[0]  = '{10'h013, 1'b1, 1'b0, 2, 6, 2'd1, 1'b0};
        vt[1]  = '{10'h1FF, 1'b1, 1'b1, 1, 6, 2'd1, 1'b0};
        vt[2]  = '{10'h1FF, 1'b1, 1'b0, 1, 6, 2'd2, 1'b0};
        vt[3]  = '{10'h0A5, 1'b1, 1'b0, 1, 6, 2'd3, 1'b0};
        vt[4]  = '{10'h155, 1'b0, 1'b0, 1, 8, 2'd3, 1'b1};
        vt[5]  = '{10'h2AA, 1'b1, 1'b0, 6, 6, 2'd3, 1'b1};
        vt[6]  = '{10'h001, 1'b1, 1'b1, 1, 6, 2'd1, 1'b0};
        vt[7]  = '{10'h002, 1'b1, 1'b0, 1, 6, 2'd2, 1'b0};
        vt[8]  = '{10'h004, 1'b1, 1'b0, 1, 6, 2'd3, 1'b0};
        vt[9]  = '{10'h008, 1'b1, 1'b0, 1, 6, 2'd3, 1'b0};
        vt[10] = '{10'h3FF, 1'b1, 1'b0, 1, 6, 2'd3, 1'b0};
        exp_link[0] = 10'h1FF;
        exp_link[1] = 10'h1FF;
        exp_link[2] = 10'h0A5;

        // Reset state
        repeat (3) tick;
        RST = 1'b1;
        tick;
        check("rst_req",  AEROUT_REQ, 0);
        check("rst_addr", AEROUT_ADDR, 0);
        check("rst_busy", AERIN_CTRL_BUSY, 0);
        check("rst_cnt",  EVT_SENT_CNT, 0);
        check("rst_tmo",  ERR_TIMEOUT, 0);
        check("rst_ovr",  ERR_OVERRUN, 0);

        // Table: single events, encoder sequence, timeout, saturation
        for (int i = 0; i < 11; i++) begin
            if (vt[i].clr_before) begin
                clr_pulse;
                check("clr_cnt", EVT_SENT_CNT, 0);
                check("clr_tmo", ERR_TIMEOUT, 0);
                link_q.delete();
            end
            repeat (vt[i].gap) tick;
            ack_en = vt[i].ack_on;
            send_event(vt[i].data, rc, a);
            check($sformatf("v%0d_addr", i), a, vt[i].data);
            check($sformatf("v%0d_reqcyc", i), rc, vt[i].exp_req_cycles);
            check($sformatf("v%0d_cnt", i), EVT_SENT_CNT, vt[i].exp_cnt);
            check($sformatf("v%0d_tmo", i), ERR_TIMEOUT, vt[i].exp_tmo);
            check($sformatf("v%0d_ovr", i), ERR_OVERRUN, 0);
            if (i == 3) begin
                check("link_size", link_q.size(), 3);
                if (link_q.size() == 3)
                    for (int j = 0; j < 3; j++)
                        check($sformatf("link_%0d", j), link_q[j], exp_link[j]);
            end
        end

        // Overrun during REQ, with a timeout flag already set
        clr_pulse;
        tick;
        ack_en = 1'b0;
        send_event(10'h0F0, rc, a);
        check("ovr_pre_tmo", ERR_TIMEOUT, 1);
        repeat (6) tick;
        ack_en = 1'b1;
        EVT_VALID = 1'b1;
        EVT_DATA  = 10'h388;
        tick;
        EVT_VALID = 1'b0;
        EVT_DATA  = 10'h077;
        tick;
        EVT_DATA  = 10'h300;
        tick;
        EVT_VALID = 1'b1;
        tick;
        EVT_VALID = 1'b0;
        check("ovr_flag", ERR_OVERRUN, 1);
        check("ovr_addr", AEROUT_ADDR, 10'h077);
        check("ovr_req",  AEROUT_REQ, 1);
        for (int k = 0; k < 60; k++) begin
            if (!AERIN_CTRL_BUSY) break;
            tick;
        end
        check("ovr_done_busy", AERIN_CTRL_BUSY, 0);
        check("ovr_done_cnt",  EVT_SENT_CNT, 1);
        check("ovr_done_addr", AEROUT_ADDR, 10'h077);
        clr_pulse;
        check("ovr_clr_ovr", ERR_OVERRUN, 0);
        check("ovr_clr_tmo", ERR_TIMEOUT, 0);
        check("ovr_clr_cnt", EVT_SENT_CNT, 0);

        // Held strobe: one event only, no re-arm while still high
        tick;
        link_q.delete();
        EVT_VALID = 1'b1;
        EVT_DATA  = 10'h2EE;
        tick;
        EVT_DATA  = 10'h111;
        repeat (24) tick;
        EVT_VALID = 1'b0;
        repeat (3) tick;
        check("hold_links", link_q.size(), 1);
        if (link_q.size() == 1) check("hold_addr", link_q[0], 10'h111);
        check("hold_cnt",  EVT_SENT_CNT, 1);
        check("hold_ovr",  ERR_OVERRUN, 0);
        check("hold_req",  AEROUT_REQ, 0);
        check("hold_busy", AERIN_CTRL_BUSY, 0);

        // Reset while in ACK_HI
        EVT_VALID = 1'b1;
        EVT_DATA  = 10'h13C;
        tick;
        EVT_VALID = 1'b0;
        EVT_DATA  = 10'h2C3;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick;
            if (seen && !AEROUT_REQ) break;
            if (AEROUT_REQ) seen = 1'b1;
        end
        check("mid_ackhi_busy", AERIN_CTRL_BUSY, 1);
        check("mid_ackhi_req",  AEROUT_REQ, 0);
        RST = 1'b0;
        tick;
        RST = 1'b1;
        check("mid_rst_req",  AEROUT_REQ, 0);
        check("mid_rst_addr", AEROUT_ADDR, 0);
        check("mid_rst_busy", AERIN_CTRL_BUSY, 0);
        check("mid_rst_cnt",  EVT_SENT_CNT, 0);
        check("mid_rst_ovr",  ERR_OVERRUN, 0);
        repeat (15) tick;
        check("mid_after_cnt",  EVT_SENT_CNT, 0);
        check("mid_after_req",  AEROUT_REQ, 0);
        check("mid_after_busy", AERIN_CTRL_BUSY, 0);

        // Clear on the completion edge beats the increment
        send_event(10'h0C3, rc, a);
        check("pre_clr_cnt", EVT_SENT_CNT, 1);
        tick;
        EVT_VALID = 1'b1;
        EVT_DATA  = 10'h3C3;
        tick;
        EVT_VALID = 1'b0;
        EVT_DATA  = 10'h03C;
        repeat (12) tick;
        CLR_STATUS = 1'b1;
        tick;
        CLR_STATUS = 1'b0;
        check("clr_done_cnt",  EVT_SENT_CNT, 0);
        check("clr_done_busy", AERIN_CTRL_BUSY, 0);
        tick;
        check("clr_done_cnt2", EVT_SENT_CNT, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
